// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB first, one bit per cycle.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             ai, bi, di, br_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign ai      = a_sr_q[0];
    assign bi      = b_sr_q[0];
    assign di      = ai ^ bi ^ br_q;
    assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    d_sr_d  = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                d_sr_d = {di, d_sr_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    diff_d  = {di, d_sr_q[WIDTH-1:1]};
                    bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last bit ai/bi are the operand sign bits and di is the result sign.
                    ovf_d   = (ai != bi) & (di != ai);
`endif
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready = (state_q == StIdle);
    assign done  = (state_q == StDone);
    assign diff  = diff_q;
    assign bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule
